// File: rtl/writeback_unit.sv
// -----------------------------------------------------------------------------
// writeback_unit
//
// Purpose:
//   Drives the register file write port. Each cycle it picks at most one
//   result to commit, in fixed priority order:
//     1. the LSU load result (never stalled, never queued);
//     2. the oldest entry of the ALU result FIFO.
//   ALU results always pass through the FIFO. The FIFO is never bypassed, so
//   an ALU result accepted at edge N commits at edge N+1 at the earliest.
//   A pending-write scoreboard tells decode which registers still have a
//   write outstanding, so it can stall on RAW hazards.
//
// Parameters:
//   FIFO_DEPTH  ALU result queue depth (power of 2, >= 2)
//   DATA_W      result / register width
//
// Ports:
//   wclk         in   sole clock, all state updates on posedge
//   rst          in   asynchronous active-high reset
//   alu_valid    in   ALU result offered
//   alu_ready    out  ALU result accepted when valid&ready at posedge (= !full)
//   alu_rd       in   ALU destination register
//   alu_data     in   ALU result
//   lsu_valid    in   load result offered, always accepted
//   lsu_rd       in   load destination register
//   lsu_data     in   load result
//   issue_valid  in   decode issued an instruction writing issue_rd
//   issue_rd     in   destination of the issued instruction
//   pending      out  bit i set = write to x(i) outstanding (bit 0 always 0)
//   rf_wen       out  register file write enable (registered)
//   rf_wsel      out  register file write select (registered)
//   rf_wdata     out  register file write data (registered)
//
// Optional feature (macro WB_FWD_EN):
//   Adds rsel1/rsel2 inputs and fwd1/fwd2 hit/data outputs. These forward the
//   registered commit to readers during the half cycle before the register
//   file's negedge write lands. Without the macro these ports are absent.
// -----------------------------------------------------------------------------
module writeback_unit #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned DATA_W     = 32
) (
   input  logic              wclk,
   input  logic              rst,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [4:0]        alu_rd,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              lsu_valid,
   input  logic [4:0]        lsu_rd,
   input  logic [DATA_W-1:0] lsu_data,
   input  logic              issue_valid,
   input  logic [4:0]        issue_rd,
   output logic [31:0]       pending,
`ifdef WB_FWD_EN
   input  logic [4:0]        rsel1,
   input  logic [4:0]        rsel2,
   output logic              fwd1_hit,
   output logic              fwd2_hit,
   output logic [DATA_W-1:0] fwd1_data,
   output logic [DATA_W-1:0] fwd2_data,
`endif
   output logic              rf_wen,
   output logic [4:0]        rf_wsel,
   output logic [DATA_W-1:0] rf_wdata
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

   // Source of this cycle's commit
   typedef enum logic [1:0] {
      SRC_IDLE = 2'd0,
      SRC_LSU  = 2'd1,
      SRC_FIFO = 2'd2
   } src_t;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [4:0]        r_q_rd   [FIFO_DEPTH];
   logic [DATA_W-1:0] r_q_data [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wptr;
   logic [PTR_W-1:0]  r_rptr;
   logic [PTR_W:0]    r_count;

   logic              r_rf_wen;
   logic [4:0]        r_rf_wsel;
   logic [DATA_W-1:0] r_rf_wdata;
   logic [31:0]       r_pending;

   // ---------------------------------------------------------------------
   // Combinational control
   // ---------------------------------------------------------------------
   src_t              w_src;
   logic [4:0]        w_cm_rd;
   logic [DATA_W-1:0] w_cm_data;
   logic              w_cm_act;
   logic              w_cm_wen;
   logic              w_push;
   logic              w_pop;
   logic              w_full;
   logic              w_empty;
   logic [31:0]       w_pend_nxt;

   // Full/empty come from the registered count only: a pop in this cycle
   // does not make room for a push in the same cycle.
   assign w_full    = (r_count == FULL_CNT);
   assign w_empty   = (r_count == '0);
   assign alu_ready = !w_full;
   assign w_push    = alu_valid && !w_full;

   always_comb begin
      w_src     = SRC_IDLE;
      w_cm_rd   = '0;
      w_cm_data = '0;
      if (lsu_valid) begin
         w_src     = SRC_LSU;
         w_cm_rd   = lsu_rd;
         w_cm_data = lsu_data;
      end else if (!w_empty) begin
         w_src     = SRC_FIFO;
         w_cm_rd   = r_q_rd[r_rptr];
         w_cm_data = r_q_data[r_rptr];
      end
   end

   assign w_pop    = (w_src == SRC_FIFO);
   assign w_cm_act = (w_src != SRC_IDLE);
   // x0 commits still consume their source but never reach the register file
   assign w_cm_wen = w_cm_act && (w_cm_rd != 5'd0);

   // Scoreboard next state: clear applied first so a same-cycle set of the
   // same register wins (a younger writer is still outstanding).
   always_comb begin
      w_pend_nxt = r_pending;
      if (w_cm_act) begin
         w_pend_nxt[w_cm_rd] = 1'b0;
      end
      if (issue_valid) begin
         w_pend_nxt[issue_rd] = 1'b1;
      end
      w_pend_nxt[0] = 1'b0;
   end

   // ---------------------------------------------------------------------
   // FIFO storage (no reset needed: contents are only read when count != 0)
   // ---------------------------------------------------------------------
   always_ff @(posedge wclk) begin
      if (w_push) begin
         r_q_rd[r_wptr]   <= alu_rd;
         r_q_data[r_wptr] <= alu_data;
      end
   end

   // ---------------------------------------------------------------------
   // FIFO pointers and count
   // ---------------------------------------------------------------------
   always_ff @(posedge wclk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PTR_W'(1);
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
            2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Commit registers: held on idle and x0 cycles so the write port only
   // changes when a real write is issued.
   // ---------------------------------------------------------------------
   always_ff @(posedge wclk or posedge rst) begin
      if (rst) begin
         r_rf_wen   <= 1'b0;
         r_rf_wsel  <= '0;
         r_rf_wdata <= '0;
      end else begin
         r_rf_wen <= w_cm_wen;
         if (w_cm_wen) begin
            r_rf_wsel  <= w_cm_rd;
            r_rf_wdata <= w_cm_data;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Pending-write scoreboard
   // ---------------------------------------------------------------------
   always_ff @(posedge wclk or posedge rst) begin
      if (rst) begin
         r_pending <= '0;
      end else begin
         r_pending <= w_pend_nxt;
      end
   end

   assign rf_wen   = r_rf_wen;
   assign rf_wsel  = r_rf_wsel;
   assign rf_wdata = r_rf_wdata;
   assign pending  = r_pending;

`ifdef WB_FWD_EN
   // Forward the committed value until the register file captures it on
   // the following negedge.
   assign fwd1_hit  = r_rf_wen && (r_rf_wsel == rsel1) && (rsel1 != 5'd0);
   assign fwd2_hit  = r_rf_wen && (r_rf_wsel == rsel2) && (rsel2 != 5'd0);
   assign fwd1_data = r_rf_wdata;
   assign fwd2_data = r_rf_wdata;
`endif

endmodule
